// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply controller.
//   XLEN      operand width (only 32 is supported)
//   ITER      shift-add iterations per multiply
//   CNT_W     width of the iteration counter
//   state_t   controller FSM encoding
//   magnitude absolute value of an operand, applied only to negative operands of MULT
package mult_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Radix-2 shift-add multiply datapath (unsigned magnitudes only).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture operand magnitudes, clear accumulator and counter
//   step            perform one shift-add iteration
//   is_signed       operands are two's-complement (MULT)
//   opr1, opr2      multiplicand, multiplier
//   acc_next        accumulator value after the current iteration
//   last            the current iteration is the final one
module mult_core
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_signed,
  input  logic [XLEN-1:0]   opr1,
  input  logic [XLEN-1:0]   opr2,
  output logic [2*XLEN-1:0] acc_next,
  output logic              last
);

  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  // Exposed combinationally so the final product can be written on the
  // same edge that completes the last iteration.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign last     = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{XLEN{1'b0}}, magnitude(opr1, is_signed)};
      mplier <= magnitude(opr2, is_signed);
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// Multi-cycle MULT/MULTU controller owning the architectural HI/LO registers.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mult_start, mult_signed      multiply request and signedness
//   mult_opr1, mult_opr2         operands, sampled with mult_start
//   hilo_rd_req                  MFHI/MFLO needs HI/LO this cycle
//   hilo_wr_en/_sel/_data        MTHI/MTLO write (sel 1 = HI)
//   busy, stall_req, done        status, pipeline stall, product-written pulse
//   hi, lo                       architectural HI/LO
//
// state | meaning
// IDLE  | HI/LO stable, accepts mult_start and MTHI/MTLO
// RUN   | one shift-add iteration per cycle, 32 cycles
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int XLEN = mult_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mult_start,
  input  logic            mult_signed,
  input  logic [XLEN-1:0] mult_opr1,
  input  logic [XLEN-1:0] mult_opr2,
  input  logic            hilo_rd_req,
  input  logic            hilo_wr_en,
  input  logic            hilo_wr_sel,
  input  logic [XLEN-1:0] hilo_wr_data,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state;
  state_t            state_next;
  logic              neg_result;
  logic              accept;
  logic              finish;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] product;
  logic              last;

  assign busy      = (state == RUN);
  assign accept    = mult_start && (state == IDLE);
  assign finish    = busy && last;
  assign stall_req = busy && (hilo_rd_req || hilo_wr_en || mult_start);
  assign product   = neg_result ? -acc_next : acc_next;

  mult_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (busy),
    .is_signed (mult_signed),
    .opr1      (mult_opr1),
    .opr2      (mult_opr2),
    .acc_next  (acc_next),
    .last      (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mult_start) state_next = RUN;
      RUN:     if (last)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      neg_result <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (accept) neg_result <= mult_signed && (mult_opr1[XLEN-1] ^ mult_opr2[XLEN-1]);
      if (finish) begin
        {hi, lo} <= product;
      end else if (hilo_wr_en && !busy) begin
        // A write coinciding with mult_start lands now; the product replaces it later.
        if (hilo_wr_sel) hi <= hilo_wr_data;
        else             lo <= hilo_wr_data;
      end
    end
  end

endmodule
